// File: rtl/triad_output_scheduler_pkg.sv
// Shared constants and types for the triad output scheduler.
// Holds the word/ID widths, the default watchdog period and the output FSM encoding.
// Also provides the modulo-N index helper used by the round-robin picker.
package triad_output_scheduler_pkg;

    // Width of one sensor_iterations word from a triad data_parser.
    localparam int TRIAD_DATA_W        = 102;
    // Width of the triad index carried alongside each output word.
    localparam int TRIAD_ID_W          = 3;
    // Largest triad count the ID width can address.
    localparam int TRIAD_MAX_TRIADS    = 1 << TRIAD_ID_W;
    // 100 ms at 72 MHz.
    localparam int TRIAD_TIMEOUT_TICKS = 7200000;

    // Output register FSM encoding.
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    typedef logic [TRIAD_ID_W-1:0] triad_id_t;

    // (base + offset) mod n, for offset in 1..n and base < n.
    function automatic triad_id_t triad_wrap_idx(input int base, input int offset, input int n);
        int sum;
        sum = base + offset;
        if (sum >= n) begin
            sum = sum - n;
        end
        return TRIAD_ID_W'(sum);
    endfunction

endpackage

// File: rtl/triad_output_scheduler_rr_picker.sv
// Round-robin picker: first set bit of full_i searching upward from ptr_i+1, modulo N_TRIADS.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the selection is consumed.
module triad_rr_picker
    import triad_output_scheduler_pkg::*;
#(
    parameter int N_TRIADS = 4
) (
    input  logic [N_TRIADS-1:0] full_i,
    input  triad_id_t           ptr_i,
    output triad_id_t           sel_o,
    output logic                any_full_o
);

    // Zero-extended copy so a TRIAD_ID_W-bit index always lands in range.
    logic [TRIAD_MAX_TRIADS-1:0] full_ext;

    assign full_ext = TRIAD_MAX_TRIADS'(full_i);

    // Scan the slots in priority order starting just after the last winner.
    always_comb begin
        triad_id_t idx;
        idx        = '0;
        sel_o      = '0;
        any_full_o = 1'b0;
        for (int k = 1; k <= N_TRIADS; k++) begin
            idx = triad_wrap_idx(int'(ptr_i), k, N_TRIADS);
            if (!any_full_o && full_ext[idx]) begin
                any_full_o = 1'b1;
                sel_o      = idx;
            end
        end
    end

endmodule

// File: rtl/triad_output_scheduler.sv
// Buffers one word per triad, drains the buffers round-robin onto one valid/ready stream, re-arms parsers.
// Latency: data_avl at edge t -> out_valid with the word after edge t+1 when idle; back-to-back when busy.
// Backpressure: out_ready low holds the presented word; a new word for a still-full slot is dropped.
module triad_output_scheduler
    import triad_output_scheduler_pkg::*;
#(
    parameter int N_TRIADS      = 4,
    parameter int DATA_W        = TRIAD_DATA_W,
    parameter int TIMEOUT_TICKS = TRIAD_TIMEOUT_TICKS
) (
    input  logic                         clk_72MHz,
    input  logic                         reset_n,
    input  logic [N_TRIADS-1:0]          data_avl,
    input  logic [N_TRIADS*DATA_W-1:0]   sensor_iterations,
    output logic [N_TRIADS-1:0]          reset_parser,
    output logic [DATA_W-1:0]            out_data,
    output logic [TRIAD_ID_W-1:0]        out_triad_id,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_TRIADS-1:0]          drop_pulse
);

    localparam int              WD_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_TICKS - 1);

    // Output FSM and presented word.
    logic [0:0]          state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    triad_id_t           out_id_q, out_id_d;
    triad_id_t           ptr_q, ptr_d;

    // Per-triad buffer slots.
    logic [N_TRIADS-1:0] full_q, full_d;
    logic [DATA_W-1:0]   slot_q [N_TRIADS];

    // Per-triad pulses and watchdogs.
    logic [N_TRIADS-1:0] rp_q, rp_d;
    logic [N_TRIADS-1:0] drop_q, drop_d;
    logic [WD_W-1:0]     wd_q [N_TRIADS];
    logic [WD_W-1:0]     wd_d [N_TRIADS];

    // Handshake between the picker, FSM and slots.
    triad_id_t           sel;
    logic                any_full;
    logic                load;
    logic [N_TRIADS-1:0] drain;
    logic [N_TRIADS-1:0] capture;
    logic [N_TRIADS-1:0] timeout;
    logic [DATA_W-1:0]   sel_data;

    triad_rr_picker #(
        .N_TRIADS   (N_TRIADS)
    ) u_picker (
        .full_i     (full_q),
        .ptr_i      (ptr_q),
        .sel_o      (sel),
        .any_full_o (any_full)
    );

    // Output FSM: load a winner when idle or when the current word is accepted.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        load        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load = any_full;
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    if (any_full) begin
                        // Back-to-back: replace the accepted word on the same edge.
                        load = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        if (load) begin
            state_d     = ST_PRESENT;
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_id_d    = sel;
            ptr_d       = sel;
        end
    end

    // Decode the winning slot into a drain strobe and mux out its word.
    always_comb begin
        drain    = '0;
        sel_data = '0;
        for (int i = 0; i < N_TRIADS; i++) begin
            if (sel == TRIAD_ID_W'(i)) begin
                sel_data = slot_q[i];
                drain[i] = load;
            end
        end
    end

    // Slot occupancy, drops, re-arm pulses and watchdog next state per triad.
    always_comb begin
        for (int i = 0; i < N_TRIADS; i++) begin
            // A slot being drained this edge is free for a new word on the same edge.
            capture[i] = data_avl[i] && (!full_q[i] || drain[i]);
            drop_d[i]  = data_avl[i] && full_q[i] && !drain[i];
            full_d[i]  = capture[i] || (full_q[i] && !drain[i]);
            // A triad that is delivering data right now is not silent.
            timeout[i] = (wd_q[i] == WD_MAX) && !data_avl[i];
            // Drain and timeout re-arms coincide into one pulse.
            rp_d[i]    = drain[i] || timeout[i];
            if (data_avl[i] || rp_d[i]) begin
                wd_d[i] = '0;
            end else if (!full_q[i]) begin
                wd_d[i] = wd_q[i] + WD_W'(1);
            end else begin
                wd_d[i] = wd_q[i];
            end
        end
    end

    // Control state with synchronous reset; parsers are held re-armed during reset.
    always_ff @(posedge clk_72MHz) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= TRIAD_ID_W'(N_TRIADS - 1);
            full_q      <= '0;
            rp_q        <= '1;
            drop_q      <= '0;
            for (int i = 0; i < N_TRIADS; i++) begin
                wd_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
            full_q      <= full_d;
            rp_q        <= rp_d;
            drop_q      <= drop_d;
            for (int i = 0; i < N_TRIADS; i++) begin
                wd_q[i] <= wd_d[i];
            end
        end
    end

    // Slot payloads need no reset: they are only read while the matching full bit is set.
    always_ff @(posedge clk_72MHz) begin
        for (int i = 0; i < N_TRIADS; i++) begin
            if (capture[i]) begin
                slot_q[i] <= sensor_iterations[i*DATA_W +: DATA_W];
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_triad_id = out_id_q;
    assign reset_parser = rp_q;
    assign drop_pulse   = drop_q;

endmodule

// File: doc/triad_output_scheduler.md
Name: triad_output_scheduler

Overview:
- Shares one output stream between N_TRIADS triad manager instances, each ending in a data_parser.
- Buffers one sensor_iterations word per triad and drains the buffers round-robin onto a single valid/ready output.
- Sequences each triad's reset_parser: re-arms a triad once its data is drained, and re-arms it on a watchdog timeout when a triad goes silent.
- Sits between the triad managers and the downstream packetiser/UART link, in the clk_72MHz domain.

Parameters:
- N_TRIADS, 4, number of triad managers served (2..8).
- DATA_W, 102, width of one sensor_iterations word.
- TIMEOUT_TICKS, 7200000, clk_72MHz cycles without a capture before the triad is re-armed (100 ms).

Ports:
- clk_72MHz  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- data_avl  input  N_TRIADS  per-triad one-cycle pulse: the matching sensor_iterations slice is valid.
- sensor_iterations  input  N_TRIADS*DATA_W  concatenated words; triad i occupies bits [i*DATA_W +: DATA_W].
- reset_parser  output  N_TRIADS  per-triad re-arm pulse to that triad's data_parser.
- out_data  output  DATA_W  presented word.
- out_triad_id  output  3  source triad index of out_data.
- out_valid  output  1  out_data/out_triad_id are valid.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.
- drop_pulse  output  N_TRIADS  one-cycle pulse when a word from triad i is discarded.

Behaviour:
- Reset (reset_n low at an edge):
  - out_valid=0, out_data=0, out_triad_id=0, drop_pulse=0.
  - All slots empty; round-robin pointer=N_TRIADS-1; watchdogs=0.
  - reset_parser is all ones while reset_n is low, so the parsers are held re-armed. It drops to all zeros on the first edge with reset_n high.
  - A reset asserted mid-transfer discards the presented word and all buffered words; no drop_pulse is raised.
- Capture:
  - On an edge with data_avl[i]=1 and slot i empty, store the slice; full[i]=1 from the next cycle.
  - If data_avl[i]=1 and slot i is still full after this edge's drain, discard the new word. The old word is kept and drop_pulse[i]=1 for one cycle.
- Output register, states IDLE and PRESENT:
  - IDLE: if any full[i], select the first full slot searching from pointer+1 upward, modulo N_TRIADS. At that edge: load out_data/out_triad_id, set out_valid=1, clear full[sel], set pointer=sel, and go to PRESENT.
  - PRESENT: hold out_data/out_triad_id stable while out_ready=0.
  - On handshake with another slot full: load the next winner on the same edge (back-to-back, no bubble) and stay in PRESENT.
  - On handshake with no slot full: out_valid=0 and go to IDLE.
- Same-cycle capture and drain of slot i: the drain frees the slot and the new word is captured on the same edge. Slot i stays full with the new word and no drop occurs.
- Latency, empty system: data_avl[i] at edge t; full at t+1; out_valid=1 with the word after edge t+1.
- Re-arm:
  - reset_parser[i] pulses high for exactly one cycle, registered, starting on the edge where slot i is loaded into the output register.
  - The triad is re-armed as soon as its word leaves the buffer, not when downstream accepts it.
- Watchdog:
  - Per-triad counter, width clog2(TIMEOUT_TICKS+1).
  - Cleared on a capture from triad i or on any reset_parser[i] pulse; otherwise increments while slot i is empty.
  - On reaching TIMEOUT_TICKS-1: pulse reset_parser[i] for one cycle and clear the counter.
  - The counter does not increment while slot i is full.
  - A watchdog pulse and a drain pulse on the same edge merge into a single one-cycle pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package: TRIAD_DATA_W=102, TRIAD_ID_W=3, default TIMEOUT_TICKS, and the IDLE/PRESENT state encoding.
- One sub-module, triad_rr_picker: combinational round-robin first-set search over the full vector, given the pointer. Outputs are sel index and any_full.
- Slots, watchdogs and the output FSM stay in the top module.

Test Plan:
- Single capture: N_TRIADS=4, data_avl=0b0100 with slice2=102'h3_1234_5678 at edge t.
  -> out_valid=1, out_triad_id=2, out_data=102'h3_1234_5678 after edge t+1.
  -> reset_parser=0b0100 for one cycle.
  -> out_valid=0 after handshake.
- Fairness: all four triads pulse on the same edge, out_ready=1 throughout.
  -> out_triad_id sequence 0,1,2,3 on four consecutive cycles, no bubbles.
  -> a second burst then starts at triad 0 again.
- Backpressure and drop: out_ready=0; triad 1 pulses twice, 10 cycles apart.
  -> the first word is held on the output.
  -> the second word is captured into slot 1, since slot 1 emptied on load.
  -> a third pulse yields drop_pulse=0b0010, and slot 1 keeps the second word.
- Watchdog: TIMEOUT_TICKS=16, no data_avl after reset.
  -> reset_parser=0b1111 pulses on cycle 16 after reset release, repeating every 16 cycles.
  -> a capture on triad 0 at cycle 10 defers triad 0's pulse.
- Same-cycle capture and drain: slot 3 full, output idle, data_avl[3]=1 on the load edge.
  -> old word presented, slot 3 holds the new word, no drop_pulse.
- Reset mid-operation: reset_n=0 for 2 cycles while out_valid=1 and two slots are full.
  -> out_valid=0 and reset_parser=0b1111 during reset.
  -> no output words after release until a new data_avl.
